// File: rtl/shift_pkg.sv
// Shared types and helpers for the shared barrel-shifter arbiter.
// The SHIFT_CARRY_EN macro (see shift_arbiter) does not affect this package.
package shift_pkg;

  localparam int unsigned SHIFT_DW = 32;
  localparam int unsigned SHIFT_AW = 8;
  localparam int unsigned SHIFT_CW = 6;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  typedef struct packed {
    logic [SHIFT_DW-1:0] data;
    shift_op_e           op;
    logic [SHIFT_AW-1:0] amt;
    logic                rrx;
    logic                cin;
  } shift_req_t;

  typedef struct packed {
    logic [SHIFT_DW-1:0] data;
    logic                cout;
  } shift_res_t;

  // ROR only ever needs the low five bits; other ops saturate at 32.
  function automatic logic [SHIFT_CW-1:0] core_amount(shift_op_e op, logic [SHIFT_AW-1:0] amt);
    if (op == SH_ROR) begin
      return {1'b0, amt[4:0]};
    end else if (amt >= SHIFT_AW'(32)) begin
      return SHIFT_CW'(32);
    end else begin
      return amt[SHIFT_CW-1:0];
    end
  endfunction

endpackage

// File: rtl/shift_arbiter_core.sv
// Combinational 32-bit barrel shifter; amount 0..32 for LSL/LSR/ASR, 0..31 for ROR.
// The SHIFT_CARRY_EN macro (see shift_arbiter) does not affect this module.
module shift_arbiter_core
  import shift_pkg::*;
(
  input  logic [SHIFT_DW-1:0] data,
  input  shift_op_e           op,
  input  logic [SHIFT_CW-1:0] amt,
  output logic [SHIFT_DW-1:0] result
);

  logic [4:0] rot;

  always_comb begin
    rot    = amt[4:0];
    result = data;
    case (op)
      SH_LSL:  result = data << amt;
      SH_LSR:  result = data >> amt;
      SH_ASR:  result = SHIFT_DW'($signed(data) >>> amt);
      SH_ROR:  result = (data >> rot) | (data << (SHIFT_CW'(32) - SHIFT_CW'(rot)));
      default: result = data;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester arbiter around the shared barrel shifter with ARM shift semantics
// and a one-entry registered result buffer. Define SHIFT_CARRY_EN to generate rsp_cout.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AMT_W  = 8,
  parameter int unsigned RR_ARB = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          rq_valid,
  output logic [1:0]          rq_ready,
  input  logic [2*DATA_W-1:0] rq_data,
  input  logic [3:0]          rq_op,
  input  logic [2*AMT_W-1:0]  rq_amt,
  input  logic [1:0]          rq_rrx,
  input  logic [1:0]          rq_cin,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_cout
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e              state;
  logic                rr_ptr;
  logic                free;
  logic                sel;
  logic                gnt;
  shift_req_t [1:0]    req;
  shift_req_t          sel_req;
  logic [SHIFT_DW-1:0] core_out;
  shift_res_t          nxt;

  // Amount-0, RRX and >=32 overrides plus carry-out around the core result.
  function automatic shift_res_t apply_rules(shift_req_t r, logic [SHIFT_DW-1:0] core_res);
    shift_res_t res;
`ifdef SHIFT_CARRY_EN
    logic [4:0] lo;
    logic       big;
    logic       at32;
`endif
    res      = '0;
    res.data = core_res;
    if (r.amt == '0) begin
      if (r.op == SH_ROR && r.rrx) res.data = {r.cin, r.data[SHIFT_DW-1:1]};
      else                         res.data = r.data;
    end
`ifdef SHIFT_CARRY_EN
    lo   = r.amt[4:0];
    big  = r.amt > SHIFT_AW'(32);
    at32 = r.amt == SHIFT_AW'(32);
    if (r.amt == '0) begin
      res.cout = (r.op == SH_ROR && r.rrx) ? r.data[0] : r.cin;
    end else begin
      case (r.op)
        SH_LSL:  res.cout = big ? 1'b0 : (at32 ? r.data[0] : r.data[5'(6'd32 - {1'b0, lo})]);
        SH_LSR:  res.cout = big ? 1'b0 : (at32 ? r.data[SHIFT_DW-1] : r.data[lo - 5'd1]);
        SH_ASR:  res.cout = (big || at32) ? r.data[SHIFT_DW-1] : r.data[lo - 5'd1];
        default: res.cout = (lo == '0) ? r.data[SHIFT_DW-1] : r.data[lo - 5'd1];
      endcase
    end
`endif
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      req[i].data = rq_data[i*DATA_W +: DATA_W];
      req[i].op   = shift_op_e'(rq_op[i*2 +: 2]);
      req[i].amt  = rq_amt[i*AMT_W +: AMT_W];
      req[i].rrx  = rq_rrx[i];
      req[i].cin  = rq_cin[i];
    end
  end

  // A slot is free when the buffer is empty or is being drained this cycle.
  always_comb begin
    free = !rst && (state == ST_EMPTY || rsp_ready);
    if (&rq_valid) sel = (RR_ARB != 0) ? rr_ptr : 1'b0;
    else           sel = rq_valid[1];
    gnt      = free && (|rq_valid);
    rq_ready = 2'b00;
    if (gnt) rq_ready[sel] = 1'b1;
  end

  assign sel_req = req[sel];

  shift_arbiter_core u_core (
    .data   (sel_req.data),
    .op     (sel_req.op),
    .amt    (core_amount(sel_req.op, sel_req.amt)),
    .result (core_out)
  );

  assign nxt       = apply_rules(sel_req, core_out);
  assign rsp_valid = (state == ST_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      rr_ptr   <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_cout <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: if (gnt) state <= ST_FULL;
        ST_FULL:  if (rsp_ready && !gnt) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
      if (gnt) begin
        rr_ptr   <= ~sel;
        rsp_id   <= sel;
        rsp_data <= nxt.data;
        rsp_cout <= nxt.cout;
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter; expected carry follows SHIFT_CARRY_EN.
module tb_shift_arbiter;

`ifdef SHIFT_CARRY_EN
  localparam bit CARRY_ON = 1'b1;
`else
  localparam bit CARRY_ON = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  op;
    logic [7:0]  a;
    logic        rrx;
    logic        cin;
    logic [31:0] ed;
    logic        ec;
  } vec_t;

  typedef struct packed {
    logic        id;
    logic [31:0] d;
    logic        c;
  } exp_t;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic [1:0]  rq_valid  = '0;
  logic [1:0]  rq_ready;
  logic [63:0] rq_data   = '0;
  logic [3:0]  rq_op     = '0;
  logic [15:0] rq_amt    = '0;
  logic [1:0]  rq_rrx    = '0;
  logic [1:0]  rq_cin    = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_cout;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  shift_arbiter #(.DATA_W(32), .AMT_W(8), .RR_ARB(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .rq_valid  (rq_valid),
    .rq_ready  (rq_ready),
    .rq_data   (rq_data),
    .rq_op     (rq_op),
    .rq_amt    (rq_amt),
    .rq_rrx    (rq_rrx),
    .rq_cin    (rq_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_cout  (rsp_cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [31:0] d, logic [1:0] op, logic [7:0] a, logic rrx,
                              logic cin, logic [31:0] ed, logic ec);
    vec_t v;
    v.d = d; v.op = op; v.a = a; v.rrx = rrx; v.cin = cin; v.ed = ed; v.ec = ec;
    return v;
  endfunction

  // Hand-computed vectors: operand, op, amount, rrx, cin -> result, carry.
  vec_t L1, L32, L33, R1, R32, R40, A40, A4, RRX, O4, O32, O36, Z, NONE;
  initial begin
    L1   = mk(32'h8000_0001, 2'b00, 8'd1,  1'b0, 1'b0, 32'h0000_0002, 1'b1);
    L32  = mk(32'h8000_0001, 2'b00, 8'd32, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
    L33  = mk(32'h8000_0001, 2'b00, 8'd33, 1'b0, 1'b1, 32'h0000_0000, 1'b0);
    R1   = mk(32'h0000_0003, 2'b01, 8'd1,  1'b0, 1'b0, 32'h0000_0001, 1'b1);
    R32  = mk(32'h8000_0001, 2'b01, 8'd32, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
    R40  = mk(32'h8000_0001, 2'b01, 8'd40, 1'b0, 1'b1, 32'h0000_0000, 1'b0);
    A40  = mk(32'h8000_0000, 2'b10, 8'd40, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    A4   = mk(32'h8000_0000, 2'b10, 8'd4,  1'b0, 1'b1, 32'hF800_0000, 1'b0);
    RRX  = mk(32'h0000_0003, 2'b11, 8'd0,  1'b1, 1'b1, 32'h8000_0001, 1'b1);
    O4   = mk(32'h0000_00F1, 2'b11, 8'd4,  1'b0, 1'b1, 32'h1000_000F, 1'b0);
    O32  = mk(32'h0000_00F1, 2'b11, 8'd32, 1'b0, 1'b1, 32'h0000_00F1, 1'b0);
    O36  = mk(32'h0000_00F1, 2'b11, 8'd36, 1'b0, 1'b1, 32'h1000_000F, 1'b0);
    Z    = mk(32'h0000_1234, 2'b00, 8'd0,  1'b0, 1'b1, 32'h0000_1234, 1'b1);
    NONE = '0;
  end

  // Drive one cycle at the falling edge, check ready/valid, push accepted expectations.
  task automatic step(input logic r, input logic v0, input vec_t x0, input logic v1, input vec_t x1,
                      input logic rdy, input logic [1:0] exp_rdy, input logic exp_vld,
                      input string tag);
    exp_t e;
    @(negedge clk);
    rst       = r;
    rq_valid  = {v1, v0};
    rq_data   = {x1.d, x0.d};
    rq_op     = {x1.op, x0.op};
    rq_amt    = {x1.a, x0.a};
    rq_rrx    = {x1.rrx, x0.rrx};
    rq_cin    = {x1.cin, x0.cin};
    rsp_ready = rdy;
    #1;
    check({tag, " rq_ready"}, 32'(rq_ready), 32'(exp_rdy));
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(exp_vld));
    if (!r) begin
      if (rq_ready[0] && v0) begin
        e.id = 1'b0; e.d = x0.ed; e.c = x0.ec & CARRY_ON;
        sb.push_back(e);
      end
      if (rq_ready[1] && v1) begin
        e.id = 1'b1; e.d = x1.ed; e.c = x1.ec & CARRY_ON;
        sb.push_back(e);
      end
    end
  endtask

  // Monitor: pop and compare whenever the consumer takes a result.
  always @(negedge clk) begin
    #2;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: got id=%0d data=%h, no result was expected", rsp_id, rsp_data);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id",   32'(rsp_id),   32'(mon_e.id));
        check("rsp_data", rsp_data,      mon_e.d);
        check("rsp_cout", 32'(rsp_cout), 32'(mon_e.c));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_id",    32'(rsp_id),    32'd0);
    check("reset rsp_data",  rsp_data,       32'd0);
    check("reset rsp_cout",  32'(rsp_cout),  32'd0);
    rst = 1'b0;

    step(0, 1, L1,   1, R1,   1, 2'b01, 0, "c1");
    step(0, 1, L32,  1, R1,   1, 2'b10, 1, "c2");
    step(0, 1, L32,  1, R32,  1, 2'b01, 1, "c3");
    step(0, 1, O4,   1, R32,  1, 2'b10, 1, "c4");
    step(0, 1, O4,   1, A40,  1, 2'b01, 1, "c5");
    for (int k = 0; k < 3; k++) begin
      step(0, 1, A4, 1, A40, 0, 2'b00, 1, "hold");
      check("hold rsp_data", rsp_data,     32'h1000_000F);
      check("hold rsp_id",   32'(rsp_id),  32'd0);
    end
    step(0, 1, A4,   1, A40,  1, 2'b10, 1, "release");
    step(0, 1, A4,   1, RRX,  1, 2'b01, 1, "c10");
    step(0, 0, NONE, 1, RRX,  1, 2'b10, 1, "c11");
    step(0, 1, O32,  0, NONE, 1, 2'b01, 1, "c12");
    step(0, 0, NONE, 1, O36,  1, 2'b10, 1, "c13");
    step(0, 1, Z,    0, NONE, 1, 2'b01, 1, "c14");
    step(0, 0, NONE, 1, R40,  1, 2'b10, 1, "c15");
    step(0, 1, L33,  0, NONE, 1, 2'b01, 1, "c16");
    step(0, 0, NONE, 0, NONE, 1, 2'b00, 1, "c17");
    step(0, 0, NONE, 0, NONE, 1, 2'b00, 0, "c18");
    step(0, 1, R1,   0, NONE, 1, 2'b01, 0, "c19");
    step(1, 1, L1,   1, R1,   0, 2'b00, 1, "rst_mid");
    sb.delete();
    step(0, 1, Z,    1, L1,   1, 2'b01, 0, "post_rst");
    step(0, 0, NONE, 0, NONE, 1, 2'b00, 1, "c22");
    step(0, 0, NONE, 0, NONE, 1, 2'b00, 0, "c23");

    @(negedge clk);
    #3;
    check("scoreboard_left", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
